// File: rtl/serdes_align_pkg.sv
// Shared definitions for the SERDES receive word-alignment controller.
// Contents: word and offset widths, the default training word and the
// alignment FSM state type.
package serdes_align_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFS_W  = 5;

  localparam logic [WORD_W-1:0] TRAIN_PAT_DEFAULT = 32'hF0E1_D2C3;

  typedef enum logic [1:0] {
    StSearch,
    StVerify,
    StLocked
  } align_state_e;

endpackage

// File: rtl/word_window_sel.sv
// 64-to-32 variable-offset window mux.
// Ports:
//   win_buf   - two buffered words, [63:32] newest, [31:0] oldest
//   shift_sel - bit offset of the window into win_buf
//   aligned   - win_buf[shift_sel+31 : shift_sel]
module word_window_sel
  import serdes_align_pkg::*;
(
  input  logic [2*WORD_W-1:0] win_buf,
  input  logic [OFS_W-1:0]    shift_sel,
  output logic [WORD_W-1:0]   aligned
);

  logic [2*WORD_W-1:0] shifted;

  always_comb begin
    shifted = win_buf >> shift_sel;
    aligned = shifted[WORD_W-1:0];
  end

endmodule

// File: rtl/word_align_ctrl.sv
// Receive word alignment controller. Buffers two deserializer words, picks a
// 32-bit window at a searched bit offset and declares lock once the training
// word has been seen LOCK_CNT times in a row; while locked and training, drops
// lock after UNLOCK_CNT consecutive mismatches.
// Ports:
//   clk, rst_n  - word clock, async active-low reset
//   din         - raw word, bit 0 earliest; din_valid qualifies it
//   train_en    - link is sending the training word (enables loss monitor)
//   realign     - one-cycle pulse: drop lock and restart the search
//   bypass      - dout carries the newest raw word instead of the window
//   dout        - aligned/bypassed word; dout_valid qualifies it
//   shift_sel   - current bit offset
//   locked      - alignment lock
//   sweep_err   - sticky: offset wrapped 31->0 without lock
module word_align_ctrl
  import serdes_align_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_PAT  = TRAIN_PAT_DEFAULT,
  parameter int unsigned       LOCK_CNT   = 4,
  parameter int unsigned       UNLOCK_CNT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  input  logic              train_en,
  input  logic              realign,
  input  logic              bypass,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  output logic [OFS_W-1:0]  shift_sel,
  output logic              locked,
  output logic              sweep_err
);

  localparam logic [3:0] LockCntW   = 4'(LOCK_CNT);
  localparam logic [7:0] UnlockCntW = 8'(UNLOCK_CNT);

  // Datapath state
  logic [2*WORD_W-1:0] buf_q;
  logic [1:0]          fill_q;
  logic                vld_d1_q;
  logic [WORD_W-1:0]   dout_q;
  logic                dout_valid_q;

  // Control state
  align_state_e state_q, state_d;
  logic [OFS_W-1:0] shift_q, shift_d;
  logic [3:0]       mcnt_q, mcnt_d;
  logic [7:0]       ucnt_q, ucnt_d;
  logic             sweep_q, sweep_d;

  logic [WORD_W-1:0] aligned;
  logic              eval;
  logic              match;
  logic [OFS_W-1:0]  shift_inc;
  logic              shift_wrap;
  logic [3:0]        mcnt_inc;
  logic [7:0]        ucnt_inc;

  word_window_sel u_window (
    .win_buf   (buf_q),
    .shift_sel (shift_q),
    .aligned   (aligned)
  );

  // Word buffer and output register. The output stage works from the buffer
  // contents loaded on the previous clock, giving a fixed two-clock latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q        <= '0;
      fill_q       <= '0;
      vld_d1_q     <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      if (din_valid) begin
        buf_q <= {din, buf_q[2*WORD_W-1:WORD_W]};
        if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      end
      vld_d1_q <= din_valid;
      if (vld_d1_q) begin
        dout_q       <= bypass ? buf_q[2*WORD_W-1:WORD_W] : aligned;
        dout_valid_q <= (fill_q == 2'd2);
      end else begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign eval       = vld_d1_q && (fill_q == 2'd2);
  assign match      = (aligned == TRAIN_PAT);
  assign shift_inc  = shift_q + 5'd1;
  assign shift_wrap = (shift_q == '1);
  assign mcnt_inc   = mcnt_q + 4'd1;
  assign ucnt_inc   = ucnt_q + 8'd1;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StSearch;
      shift_q <= '0;
      mcnt_q  <= '0;
      ucnt_q  <= '0;
      sweep_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      mcnt_q  <= mcnt_d;
      ucnt_q  <= ucnt_d;
      sweep_q <= sweep_d;
    end
  end

  // FSM: next state. realign overrides any eval in the same cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    mcnt_d  = mcnt_q;
    ucnt_d  = ucnt_q;
    sweep_d = sweep_q;
    if (realign) begin
      state_d = StSearch;
      mcnt_d  = '0;
      ucnt_d  = '0;
      sweep_d = 1'b0;
    end else if (eval) begin
      unique case (state_q)
        StSearch: begin
          if (match) begin
            if (LockCntW == 4'd1) begin
              state_d = StLocked;
              mcnt_d  = '0;
              sweep_d = 1'b0;
            end else begin
              state_d = StVerify;
              mcnt_d  = 4'd1;
            end
          end else begin
            shift_d = shift_inc;
            if (shift_wrap) sweep_d = 1'b1;
          end
        end
        StVerify: begin
          if (match) begin
            if (mcnt_inc == LockCntW) begin
              state_d = StLocked;
              mcnt_d  = '0;
              sweep_d = 1'b0;
            end else begin
              mcnt_d = mcnt_inc;
            end
          end else begin
            state_d = StSearch;
            mcnt_d  = '0;
            shift_d = shift_inc;
            if (shift_wrap) sweep_d = 1'b1;
          end
        end
        StLocked: begin
          // Offset stays frozen; on loss the search resumes from here.
          if (!train_en || match) begin
            ucnt_d = '0;
          end else if (ucnt_inc == UnlockCntW) begin
            state_d = StSearch;
            ucnt_d  = '0;
          end else begin
            ucnt_d = ucnt_inc;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    locked     = (state_q == StLocked);
    shift_sel  = shift_q;
    sweep_err  = sweep_q;
    dout       = dout_q;
    dout_valid = dout_valid_q;
  end

endmodule

// File: tb/tb_word_align_ctrl.sv
// Self-checking bench for word_align_ctrl against a word-level reference
// model: the model keeps the last two words, an offset, a run of consecutive
// training hits and a run of misses, and predicts every output each clock.
module tb_word_align_ctrl;

  localparam logic [31:0] TRAIN  = 32'hF0E1_D2C3;
  localparam int          LOCK   = 4;
  localparam int          UNLOCK = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        din_valid;
  logic        train_en;
  logic        realign;
  logic        bypass;
  logic [31:0] dout;
  logic        dout_valid;
  logic [4:0]  shift_sel;
  logic        locked;
  logic        sweep_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_old, m_new, m_dout;
  int          m_fill, m_ofs, m_mode, m_run, m_miss;  // mode 0 search, 1 verify, 2 locked
  bit          m_pend, m_dv, m_sweep;

  // Stream = TRAIN repeated, delayed by 7 bits (zeros first)
  logic [31:0] w0, wr;

  always #5 clk = ~clk;

  word_align_ctrl #(
    .TRAIN_PAT  (TRAIN),
    .LOCK_CNT   (LOCK),
    .UNLOCK_CNT (UNLOCK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .train_en   (train_en),
    .realign    (realign),
    .bypass     (bypass),
    .dout       (dout),
    .dout_valid (dout_valid),
    .shift_sel  (shift_sel),
    .locked     (locked),
    .sweep_err  (sweep_err)
  );

  function automatic logic [39:0] exp_vec();
    return {m_dv, m_dout, 5'(m_ofs), (m_mode == 2), m_sweep};
  endfunction

  function automatic logic [39:0] act_vec();
    return {dout_valid, dout, shift_sel, locked, sweep_err};
  endfunction

  task automatic model_reset();
    m_old = '0; m_new = '0; m_dout = '0;
    m_fill = 0; m_ofs = 0; m_mode = 0; m_run = 0; m_miss = 0;
    m_pend = 0; m_dv = 0; m_sweep = 0;
  endtask

  task automatic model_clock(input bit v, input logic [31:0] d, input bit te, input bit ra,
                             input bit bp);
    logic [63:0] pair;
    logic [31:0] win;
    bit ev, hit;
    pair = {m_new, m_old};
    win  = 32'(pair >> m_ofs);
    ev   = m_pend && (m_fill == 2);
    hit  = (win == TRAIN);
    if (m_pend) begin
      m_dout = bp ? m_new : win;
      m_dv   = (m_fill == 2);
    end else begin
      m_dv = 0;
    end
    if (ra) begin
      m_mode = 0; m_run = 0; m_miss = 0; m_sweep = 0;
    end else if (ev) begin
      if (m_mode == 2) begin
        if (!te || hit) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss == UNLOCK) begin m_mode = 0; m_miss = 0; end
        end
      end else if (hit) begin
        m_run++;
        if (m_run >= LOCK) begin m_mode = 2; m_run = 0; m_sweep = 0; end
        else m_mode = 1;
      end else begin
        m_run = 0; m_mode = 0;
        if (m_ofs == 31) m_sweep = 1;
        m_ofs = (m_ofs + 1) % 32;
      end
    end
    if (v) begin
      m_old = m_new; m_new = d;
      if (m_fill < 2) m_fill++;
    end
    m_pend = v;
  endtask

  // One clock: drive inputs, clock, advance the model, settle 1 time unit.
  task automatic step(input bit v, input logic [31:0] d, input bit te, input bit ra, input bit bp);
    din_valid = v; din = d; train_en = te; realign = ra; bypass = bp;
    @(posedge clk);
    model_clock(v, d, te, ra, bp);
    #1;
    realign = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0; din_valid = 1'b0; realign = 1'b0; bypass = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (act_vec() !== '0) begin
      miscompares++;
      $display("FAIL %s reset outputs: got %h want 0", tag, act_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = '0; din_valid = 0; train_en = 1; realign = 0; bypass = 0;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (act_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", act_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 40; i++) begin
      step(1, '0, 1, 0, 0);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL sweep step %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_lock();
    do_reset("lock");
    for (int i = 0; i < 16; i++) begin
      step(1, (i == 0) ? w0 : wr, 1, 0, 0);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL lock step %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      // Lock is declared on the 11th eval, one clock after the 12th load.
      if (i == 11 || i == 12) begin
        vectors++;
        if (locked !== (i == 12) || shift_sel !== 5'd7) begin
          miscompares++;
          $display("FAIL lock_point step %0d: locked=%b ofs=%0d want locked=%b ofs=7",
                   i, locked, shift_sel, (i == 12));
        end
      end
    end
    vectors++;
    if (dout !== TRAIN || sweep_err !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_dout: got %h err=%b want %h err=0", dout, sweep_err, TRAIN);
    end
  endtask

  task automatic test_unlock();
    logic [31:0] w;
    // Corrupt only the bits the window takes from the older word so each bad
    // word causes exactly one mismatching eval.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 9 + ph; i++) begin
        w = wr;
        if (i < 7 + ph) w = wr ^ (($urandom | 32'h100) & 32'hFFFF_FF80);
        step(1, w, 1, 0, 0);
        vectors++;
        if (act_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL unlock ph%0d step %0d: got %h want %h", ph, i, act_vec(), exp_vec());
        end
      end
      vectors++;
      if (locked !== (ph == 0) || shift_sel !== 5'd7) begin
        miscompares++;
        $display("FAIL unlock_ph%0d: locked=%b ofs=%0d want locked=%b ofs=7",
                 ph, locked, shift_sel, (ph == 0));
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1, wr, 1, 0, 0);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL relock step %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL relock_done: locked=%b want 1", locked);
    end
  endtask

  task automatic test_train_off();
    for (int i = 0; i < 1002; i++) begin
      step(1, (i < 1000) ? $urandom : wr, 0, 0, 0);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL train_off step %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    vectors++;
    if (locked !== 1'b1 || shift_sel !== 5'd7) begin
      miscompares++;
      $display("FAIL train_off_hold: locked=%b ofs=%0d want 1/7", locked, shift_sel);
    end
    step(0, '0, 0, 1, 0);
    vectors++;
    if (locked !== 1'b0 || shift_sel !== 5'd7 || act_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL realign: got %h want %h", act_vec(), exp_vec());
    end
    for (int i = 0; i < 5; i++) begin
      step(1, wr, 1, 0, 0);
      vectors++;
      if (act_vec() !== exp_vec() || locked !== (i == 4) || shift_sel !== 5'd7) begin
        miscompares++;
        $display("FAIL realign_relock step %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_bypass();
    bit bp;
    do_reset("bypass");
    for (int i = 0; i < 20; i++) begin
      bp = 1'($urandom_range(0, 1));
      step(1, (i == 0) ? w0 : wr, 1, 0, bp);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL bypass step %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    step(1, 32'h1234_5678, 1, 0, 1);
    step(1, wr, 1, 0, 1);
    vectors++;
    if (dout !== 32'h1234_5678 || dout_valid !== 1'b1 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_word: got %h v=%b lk=%b want 12345678 v=1 lk=1",
               dout, dout_valid, locked);
    end
  endtask

  task automatic test_valid_toggle_reset();
    bit v;
    int nload;
    do_reset("toggle");
    nload = 0;
    for (int i = 0; i < 200 && m_mode != 1; i++) begin
      v = (i % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      step(v, v ? ((nload == 0) ? w0 : wr) : $urandom, 1, 0, 1'($urandom_range(0, 1)));
      if (v) nload++;
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL toggle step %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    vectors++;
    if (m_mode != 1 || shift_sel !== 5'd7) begin
      miscompares++;
      $display("FAIL toggle_verify: ofs=%0d want 7 (verify reached=%0d)", shift_sel, m_mode == 1);
    end
    do_reset("mid_verify");
    for (int i = 0; i < 3; i++) begin
      step(1, (i == 0) ? w0 : wr, 1, 0, 0);
      vectors++;
      if (act_vec() !== exp_vec() || dout_valid !== (i == 2)) begin
        miscompares++;
        $display("FAIL refill step %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    w0 = TRAIN << 7;
    wr = (TRAIN << 7) | (TRAIN >> 25);
    test_reset();
    test_sweep();
    test_lock();
    test_unlock();
    test_train_off();
    test_bypass();
    test_valid_toggle_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/word_align_ctrl.md
Name: word_align_ctrl

Overview:
- Alignment controller for the 32-bit SERDES receive word path.
- Buffers two consecutive deserializer words and selects a 32-bit window at a run-time bit offset (0..31).
- Sweeps the offset until a known training word is seen LOCK_CNT times in a row, then holds lock and monitors for loss while training is enabled.
- Sits between the deserializer output and the frame/decoder logic. Replaces a fixed-offset shift with a searched one; a bypass path is kept.

Parameters:
TRAIN_PAT, 32'hF0E1_D2C3, training word expected after alignment
LOCK_CNT, 4, consecutive matches required to declare lock (1..15)
UNLOCK_CNT, 8, consecutive mismatches in LOCKED (train_en=1) that drop lock (1..255)

Ports:
clk  input  1  receive word clock
rst_n  input  1  asynchronous active-low reset
din  input  32  raw deserializer word, bit 0 earliest
din_valid  input  1  din qualifier
train_en  input  1  1 = link is sending TRAIN_PAT; enables compare in LOCKED
realign  input  1  single-cycle pulse: drop lock, restart search
bypass  input  1  1 = dout carries the newest raw word, unaligned
dout  output  32  aligned (or bypassed) word
dout_valid  output  1  dout qualifier
shift_sel  output  5  current bit offset
locked  output  1  alignment lock
sweep_err  output  1  sticky; set when the offset wraps 31->0 without lock; cleared on lock or realign

Behaviour:
- Reset (async, rst_n=0): all outputs 0, buffer 0, fill=0, state SEARCH, offset 0, all counters 0.
- Buffer:
  - On din_valid: buf[63:32]<=din and buf[31:0]<=buf[63:32]; fill saturates at 2.
  - din_valid=0: nothing advances (buffer, FSM, counters hold).
- Window: aligned = buf[shift_sel+31 : shift_sel].
- Output register, updated on the cycle after each buffer load:
  - dout <= bypass ? buf[63:32] : aligned; dout_valid <= 1 when fill==2, else 0.
  - dout_valid is 0 on all other cycles; dout holds its value.
  - Latency: din edge -> dout edge = 2 clocks.
- Eval strobe: eval = (din_valid delayed 1) & (fill==2). FSM acts only on eval cycles, using match = (aligned == TRAIN_PAT).
- Offset changes take effect on the next eval; no flush is needed because the window is selected combinationally from the held buffer.
- FSM states:
  - SEARCH:
    - match -> VERIFY, mcnt=1.
    - No match -> shift_sel+1 mod 32. On wrap 31->0, set sweep_err.
  - VERIFY:
    - match -> mcnt+1; when mcnt reaches LOCK_CNT -> LOCKED, locked=1, sweep_err=0.
    - No match -> shift_sel+1 mod 32, -> SEARCH, mcnt=0.
  - LOCKED:
    - shift_sel frozen.
    - If train_en: mismatch increments ucnt, match clears ucnt. When ucnt reaches UNLOCK_CNT -> SEARCH, locked=0, shift_sel held, so search resumes at the current offset.
    - If train_en=0: ucnt held at 0, lock never drops except via realign.
- LOCK_CNT=1: the first match goes directly SEARCH -> LOCKED.
- bypass affects dout only; the FSM runs unchanged.
- realign (highest priority, any state, takes precedence over a simultaneous eval):
  - -> SEARCH; locked, mcnt, ucnt and sweep_err cleared next clock; shift_sel held.
  - Buffer still loads if din_valid is also high.
- Reset mid-operation: immediate return to reset values; the buffer refills, so dout_valid stays 0 until the second valid word after release.

Decomposition:
- Package serdes_align_pkg holds:
  - the state enum (SEARCH/VERIFY/LOCKED);
  - the default TRAIN_PAT constant;
  - WORD_W=32 and OFS_W=5.
- One sub-module, word_window_sel: the 64-to-32 variable-offset window mux (purely combinational, buf and shift_sel in, aligned out). The FSM, counters and buffers stay in word_align_ctrl.

Test Plan:
- Reset release, continuous din_valid with din=0 -> dout_valid rises 1 clock after the 2nd word load; shift_sel steps 0,1,2…31,0; sweep_err=1 after the wrap; locked stays 0.
- Bit stream = TRAIN_PAT repeated and delayed by 7 bits, din_valid always 1 -> shift_sel stops at 7 after 7 mismatching evals. locked=1 on the 11th eval (1 clock after the 12th word load); dout=32'hF0E1_D2C3 thereafter; sweep_err=0.
- Locked at offset 7, train_en=1, 7 corrupted words then a good word -> stays locked (ucnt cleared). Then 8 corrupted words -> locked=0 on the 8th eval; search restarts from offset 7.
- Locked, train_en=0, random data for 1000 words -> locked stays 1 and shift_sel stays 7. A realign pulse -> locked=0 next clock; relock is at offset 7 after 4 evals once training resumes.
- Bypass=1 at any state with din=32'h1234_5678 -> dout=32'h1234_5678 2 clocks later; FSM progress identical to bypass=0.
- din_valid toggling 1/0 during search, plus rst_n asserted mid-VERIFY -> no state, offset or counter change on invalid cycles. On reset all outputs are 0 immediately and dout_valid stays 0 until 2 new valid words.
